// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST engine for a single-port SRAM macro.
// Walks the six March C- elements with one macro operation per cycle,
// compares read data one cycle after each read and keeps a sticky
// fail flag, the first failing address and a saturating fail count.
module sram_march_bist_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 48,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = '0,
    parameter int                    FCNT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [FCNT_WIDTH-1:0] fail_count,
    output logic                  bist_en,
    output logic                  bist_men,
    output logic                  bist_wen,
    output logic                  bist_ren,
    output logic [ADDR_WIDTH-1:0] bist_addr,
    output logic [DATA_WIDTH-1:0] bist_din,
    output logic [DATA_WIDTH-1:0] bist_bm,
    input  logic [DATA_WIDTH-1:0] bist_dout
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    // elem/ptr/phase always describe the operation currently on the bus
    state_t                  state, state_n;
    logic [2:0]              elem, elem_n;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_n;
    logic                    phase, phase_n;
    logic                    issue, is_rd, two_op, down, launch;

    logic                    pend_q;
    logic [DATA_WIDTH-1:0]   exp_q;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q;
    logic                    mismatch;

    // Next state and next operation; elements 1..4 are read-then-write,
    // elements 3 and 4 walk downward.
    always_comb begin
        state_n = state;
        elem_n  = elem;
        ptr_n   = ptr;
        phase_n = phase;
        issue   = 1'b0;
        launch  = 1'b0;
        two_op  = (elem >= 3'd1) && (elem <= 3'd4);
        down    = (elem == 3'd3) || (elem == 3'd4);
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    elem_n  = 3'd0;
                    ptr_n   = '0;
                    phase_n = 1'b0;
                    issue   = 1'b1;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                if (elem == 3'd5 && ptr == LAST) begin
                    state_n = DRAIN;
                end else begin
                    issue = 1'b1;
                    if (two_op && !phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (down) begin
                            if (ptr == '0) begin
                                elem_n = elem + 3'd1;
                                ptr_n  = (elem == 3'd3) ? LAST : '0;
                            end else begin
                                ptr_n = ptr - 1'b1;
                            end
                        end else begin
                            if (ptr == LAST) begin
                                elem_n = elem + 3'd1;
                                ptr_n  = (elem == 3'd2) ? LAST : '0;
                            end else begin
                                ptr_n = ptr + 1'b1;
                            end
                        end
                    end
                end
            end
            DRAIN:   state_n = DONE;
            default: state_n = IDLE;
        endcase
        is_rd = (elem_n == 3'd5) || ((elem_n != 3'd0) && !phase_n);
    end

    assign mismatch = pend_q && (bist_dout != exp_q);

    // State and march position registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            elem  <= 3'd0;
            ptr   <= '0;
            phase <= 1'b0;
        end else begin
            state <= state_n;
            elem  <= elem_n;
            ptr   <= ptr_n;
            phase <= phase_n;
        end
    end

    // Registered status and macro port drive for the next cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            bist_en   <= 1'b0;
            bist_men  <= 1'b0;
            bist_wen  <= 1'b0;
            bist_ren  <= 1'b0;
            bist_addr <= '0;
            bist_din  <= '0;
            bist_bm   <= '0;
        end else begin
            busy     <= (state_n == RUN) || (state_n == DRAIN);
            bist_en  <= (state_n == RUN) || (state_n == DRAIN);
            done     <= (state_n == DONE);
            bist_men <= issue;
            bist_wen <= issue && !is_rd;
            bist_ren <= issue && is_rd;
            bist_bm  <= '0;
            if (issue) begin
                bist_addr <= ptr_n;
                if (!is_rd) begin
                    // odd elements write the inverted background
                    bist_din <= elem_n[0] ? ~PATTERN : PATTERN;
                    bist_bm  <= '1;
                end
            end
        end
    end

    // Read compare one cycle after the read, plus result bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q     <= 1'b0;
            exp_q      <= '0;
            cmp_addr_q <= '0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else begin
            pend_q     <= bist_ren;
            // odd elements read the plain background, even ones the inverse
            exp_q      <= elem[0] ? PATTERN : ~PATTERN;
            cmp_addr_q <= bist_addr;
            if (launch) begin
                fail       <= 1'b0;
                fail_addr  <= '0;
                fail_count <= '0;
            end else if (mismatch) begin
                fail <= 1'b1;
                if (!fail) fail_addr <= cmp_addr_q;
                if (fail_count != '1) fail_count <= fail_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for the March C- BIST controller: a DEPTH=4 interface trace from a
// vector table, plus DEPTH=256 runs against a behavioural macro with
// injectable stuck-at faults and a loop-level March C- reference model.
module tb_sram_march_bist_ctrl;

    localparam int AW = 8;
    localparam int DW = 48;
    localparam int FW = 16;
    localparam logic [DW-1:0] PAT = '0;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // March C- as data: op 0=w0 1=w1 2=r0 3=r1
    int el_n  [6]    = '{1, 2, 2, 2, 2, 1};
    int el_op [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
    bit el_dn [6]    = '{0, 0, 0, 1, 1, 0};

    // ---------------- DUT a: DEPTH=256 ----------------
    logic          start_a, busy_a, done_a, fail_a;
    logic [AW-1:0] fail_addr_a, addr_a;
    logic [FW-1:0] fail_count_a;
    logic          en_a, men_a, wen_a, ren_a;
    logic [DW-1:0] din_a, bm_a, dout_a;

    sram_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256),
                           .PATTERN(PAT), .FCNT_WIDTH(FW)) dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .busy(busy_a), .done(done_a),
        .fail(fail_a), .fail_addr(fail_addr_a), .fail_count(fail_count_a),
        .bist_en(en_a), .bist_men(men_a), .bist_wen(wen_a), .bist_ren(ren_a),
        .bist_addr(addr_a), .bist_din(din_a), .bist_bm(bm_a), .bist_dout(dout_a)
    );

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] s1    [256];
    logic [DW-1:0] s0    [256];

    // Behavioural macro with stuck-at faults seen on the read path
    always @(posedge CLK) begin
        if (men_a) begin
            if (wen_a) mem_a[addr_a] <= (din_a & bm_a) | (mem_a[addr_a] & ~bm_a);
            else if (ren_a) dout_a <= (mem_a[addr_a] | s1[addr_a]) & ~s0[addr_a];
        end
    end

    // ---------------- DUT b: DEPTH=4 ----------------
    logic          start_b, busy_b, done_b, fail_b;
    logic [AW-1:0] fail_addr_b, addr_b;
    logic [FW-1:0] fail_count_b;
    logic          en_b, men_b, wen_b, ren_b;
    logic [DW-1:0] din_b, bm_b, dout_b;

    sram_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4),
                           .PATTERN(PAT), .FCNT_WIDTH(FW)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .busy(busy_b), .done(done_b),
        .fail(fail_b), .fail_addr(fail_addr_b), .fail_count(fail_count_b),
        .bist_en(en_b), .bist_men(men_b), .bist_wen(wen_b), .bist_ren(ren_b),
        .bist_addr(addr_b), .bist_din(din_b), .bist_bm(bm_b), .bist_dout(dout_b)
    );

    logic [DW-1:0] mem_b [256];

    always @(posedge CLK) begin
        if (men_b) begin
            if (wen_b) mem_b[addr_b] <= (din_b & bm_b) | (mem_b[addr_b] & ~bm_b);
            else if (ren_b) dout_b <= mem_b[addr_b];
        end
    end

    // Monitor for DUT a: cumulative counters, sampled away from the edge
    int busy_cyc = 0;
    int men_cnt  = 0;
    int en_mis   = 0;
    int men_idle = 0;
    always @(negedge CLK) begin
        if (busy_a) busy_cyc++;
        if (men_a) men_cnt++;
        if (en_a !== busy_a) en_mis++;
        if (men_a && !busy_a) men_idle++;
    end

    typedef struct {
        bit            wr;
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // March C- over the fault map with plain loops; returns what a correct
    // controller must report and how many operations it must issue
    function automatic void march_ref(output int cnt, output int faddr,
                                      output bit f, output int nops);
        logic [DW-1:0] m [256];
        logic [DW-1:0] ex, got;
        int a, op;
        cnt = 0; faddr = 0; f = 0; nops = 0;
        for (int i = 0; i < 256; i++) m[i] = '0;
        for (int e = 0; e < 6; e++)
            for (int k = 0; k < 256; k++) begin
                a = el_dn[e] ? 255 - k : k;
                for (int o = 0; o < el_n[e]; o++) begin
                    op = el_op[e][o];
                    nops++;
                    if (op == 0) m[a] = PAT;
                    else if (op == 1) m[a] = ~PAT;
                    else begin
                        ex  = (op == 3) ? ~PAT : PAT;
                        got = (m[a] | s1[a]) & ~s0[a];
                        if (got !== ex) begin
                            if (!f) faddr = a;
                            f = 1;
                            cnt++;
                        end
                    end
                end
            end
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin
            s1[i] = '0;
            s0[i] = '0;
        end
    endtask

    // Returns at the negedge where the first operation is on the bus
    task automatic launch_a();
        @(negedge CLK) start_a = 1'b1;
        @(negedge CLK) start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int extra, output bit tmo);
        tmo = 1'b1;
        for (int c = 1; c < 30000; c++) begin
            if (done_a) begin
                tmo = 1'b0;
                break;
            end
            @(negedge CLK);
            start_a = (c + 1 == extra);
        end
        start_a = 1'b0;
    endtask

    task automatic run_a(input int extra, output int bc);
        int b0;
        bit tmo;
        b0 = busy_cyc;
        launch_a();
        wait_done_a(extra, tmo);
        chk("run_timeout", 64'(tmo), 64'd0);
        bc = busy_cyc - b0;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({busy_a, done_a, fail_a, en_a, men_a, wen_a, ren_a}), 64'd0);
        chk({tag, "_fail_addr"}, 64'(fail_addr_a), 64'd0);
        chk({tag, "_fail_count"}, 64'(fail_count_a), 64'd0);
        chk({tag, "_addr"}, 64'(addr_a), 64'd0);
        chk({tag, "_din"}, 64'(din_a), 64'd0);
        chk({tag, "_bm"}, 64'(bm_a), 64'd0);
    endtask

    initial begin
        int bc, ec, ea, eops, m0, n, fa, fb;
        bit ef, tmo;
        vec_t v;

        start_a = 1'b0;
        start_b = 1'b0;
        clear_faults();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = DW'({$urandom, $urandom});
            mem_b[i] = DW'({$urandom, $urandom});
        end

        // expected DEPTH=4 interface trace
        for (int e = 0; e < 6; e++)
            for (int k = 0; k < 4; k++)
                for (int o = 0; o < el_n[e]; o++) begin
                    v.wr   = (el_op[e][o] < 2);
                    v.rd   = (el_op[e][o] >= 2);
                    v.addr = AW'(el_dn[e] ? 3 - k : k);
                    v.din  = (el_op[e][o] == 1) ? ~PAT : PAT;
                    tv.push_back(v);
                end

        repeat (3) @(negedge CLK);
        chk_a_zero("reset");
        RST = 1'b0;

        // ---- DEPTH=4 cycle-by-cycle trace ----
        @(negedge CLK) start_b = 1'b1;
        @(negedge CLK) start_b = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            if (i > 0) @(negedge CLK);
            chk($sformatf("trace%0d_ctrl", i), 64'({busy_b, en_b, men_b, wen_b, ren_b}),
                64'({3'b111, tv[i].wr, tv[i].rd}));
            chk($sformatf("trace%0d_addr", i), 64'(addr_b), 64'(tv[i].addr));
            chk($sformatf("trace%0d_bm", i), 64'(bm_b), tv[i].wr ? 64'({DW{1'b1}}) : 64'd0);
            if (tv[i].wr) chk($sformatf("trace%0d_din", i), 64'(din_b), 64'(tv[i].din));
        end
        @(negedge CLK);
        chk("trace_drain", 64'({busy_b, en_b, men_b, done_b}), 64'b1100);
        @(negedge CLK);
        chk("trace_done", 64'({busy_b, en_b, men_b, done_b, fail_b}), 64'b00010);
        chk("trace_results", 64'({fail_count_b, fail_addr_b}), 64'd0);

        // ---- fault-free DEPTH=256 ----
        run_a(-1, bc);
        chk("clean_busy_len", 64'(bc), 64'd2561);
        chk("clean_done", 64'({done_a, busy_a, en_a}), 64'b100);
        chk("clean_fail", 64'(fail_a), 64'd0);
        chk("clean_count", 64'(fail_count_a), 64'd0);

        // ---- stuck-at-1, bit 3 of 0x5A ----
        s1[8'h5A] = 48'h8;
        run_a(-1, bc);
        chk("sa1_busy_len", 64'(bc), 64'd2561);
        chk("sa1_fail", 64'(fail_a), 64'd1);
        chk("sa1_addr", 64'(fail_addr_a), 64'h5A);
        chk("sa1_count", 64'(fail_count_a), 64'd3);

        // ---- start at cycle 100 is ignored ----
        run_a(100, bc);
        chk("restart_busy_len", 64'(bc), 64'd2561);
        chk("restart_count", 64'(fail_count_a), 64'd3);

        // ---- second start clears results and reruns ----
        clear_faults();
        bc = busy_cyc;
        launch_a();
        chk("rerun_cleared", 64'({done_a, fail_a, busy_a, en_a}), 64'b0011);
        chk("rerun_count_clr", 64'(fail_count_a), 64'd0);
        wait_done_a(-1, tmo);
        chk("rerun_timeout", 64'(tmo), 64'd0);
        chk("rerun_busy_len", 64'(busy_cyc - bc), 64'd2561);
        chk("rerun_fail", 64'({done_a, fail_a}), 64'b10);

        // ---- stuck-at-0, bit 0 of 0x10 and 0x20 ----
        s0[8'h10] = 48'h1;
        s0[8'h20] = 48'h1;
        run_a(-1, bc);
        chk("sa0_busy_len", 64'(bc), 64'd2561);
        chk("sa0_addr", 64'(fail_addr_a), 64'h10);
        chk("sa0_count", 64'(fail_count_a), 64'd4);

        // ---- reset in the middle of M3 ----
        clear_faults();
        launch_a();
        repeat (1500) @(negedge CLK);
        chk("midrst_busy", 64'(busy_a), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk_a_zero("midrst");
        RST = 1'b0;
        m0 = men_cnt;
        repeat (30) @(negedge CLK);
        chk("midrst_no_men", 64'(men_cnt - m0), 64'd0);
        chk("midrst_idle", 64'({busy_a, done_a}), 64'd0);
        run_a(-1, bc);
        chk("postrst_busy_len", 64'(bc), 64'd2561);
        chk("postrst_result", 64'({done_a, fail_a}), 64'b10);

        // ---- random fault maps against the reference model ----
        for (int r = 0; r < 4; r++) begin
            clear_faults();
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                fa = $urandom_range(0, 255);
                fb = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) s1[fa][fb] = 1'b1;
                else s0[fa][fb] = 1'b1;
            end
            march_ref(ec, ea, ef, eops);
            run_a(-1, bc);
            chk($sformatf("rnd%0d_busy_len", r), 64'(bc), 64'(eops + 1));
            chk($sformatf("rnd%0d_fail", r), 64'(fail_a), 64'(ef));
            if (ef) chk($sformatf("rnd%0d_addr", r), 64'(fail_addr_a), 64'(ea));
            chk($sformatf("rnd%0d_count", r), 64'(fail_count_a), 64'(ec));
        end

        chk("en_tracks_busy", 64'(en_mis), 64'd0);
        chk("men_outside_run", 64'(men_idle), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
